// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one async SRAM between a fixed-latency display read port and a FIFO-buffered write port.
// Optional SRAM_ARB_STATS_EN adds wr_count, the per-blanking count of completed SRAM writes.
module sram_arbiter #(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 20
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          disp_active,
    input  logic                          disp_req,
    input  logic [ADDR_W-1:0]             disp_addr,
    output logic                          disp_valid,
    output logic [15:0]                   disp_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [15:0]                   wr_data,
    input  logic [1:0]                    wr_be,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          ovr_err,
`ifdef SRAM_ARB_STATS_EN
    output logic [15:0]                   wr_count,
`endif
    output logic [ADDR_W-1:0]             SRAM_ADDR,
    inout  wire  [15:0]                   SRAM_DQ,
    output logic                          SRAM_OE_N,
    output logic                          SRAM_WE_N,
    output logic                          SRAM_CE_N,
    output logic                          SRAM_LB_N,
    output logic                          SRAM_UB_N
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, READ, WRITE, TURN} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [15:0]       d;
        logic [1:0]        be;
    } entry_t;

    entry_t        mem [FIFO_DEPTH];
    entry_t        head;
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          push, pop, empty, can_w, drop, dq_oe;
    logic [15:0]   dq_out;
    state_t        state, nxt;

    assign head       = mem[rd_ptr[AW-1:0]];
    assign fifo_level = wr_ptr - rd_ptr;
    assign empty      = wr_ptr == rd_ptr;
    assign wr_ready   = fifo_level != (AW+1)'(FIFO_DEPTH);
    assign push       = wr_valid && wr_ready;
    assign SRAM_DQ    = dq_oe ? dq_out : 16'hzzzz;

    // Write FIFO storage; pointers carry the reset, so the array needs none.
    always_ff @(posedge clk)
        if (push) mem[wr_ptr[AW-1:0]] <= '{wr_addr, wr_data, wr_be};

    // Next state: display wins from IDLE/TURN/READ; writes drain only in blanking, empty-mask entries are just popped.
    always_comb begin
        can_w = !disp_active && !empty;
        pop   = (state == IDLE || state == TURN) && !disp_req && can_w;
        nxt   = state == WRITE ? TURN :
                disp_req ? READ :
                state == READ ? IDLE :
                pop && head.be != 2'b00 ? WRITE : IDLE;
    end

    // State, FIFO pointers, registered SRAM pins and the display return path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            SRAM_ADDR  <= '0;
            SRAM_CE_N  <= 1'b1;
            SRAM_OE_N  <= 1'b1;
            SRAM_WE_N  <= 1'b1;
            SRAM_LB_N  <= 1'b1;
            SRAM_UB_N  <= 1'b1;
            dq_oe      <= 1'b0;
            dq_out     <= '0;
            drop       <= 1'b0;
            disp_valid <= 1'b0;
            disp_data  <= '0;
            ovr_err    <= 1'b0;
        end else begin
            state      <= nxt;
            wr_ptr     <= wr_ptr + (AW+1)'(push);
            rd_ptr     <= rd_ptr + (AW+1)'(pop);
            SRAM_ADDR  <= nxt == READ ? disp_addr : nxt == WRITE ? head.a : SRAM_ADDR;
            SRAM_CE_N  <= !(nxt == READ || nxt == WRITE);
            SRAM_OE_N  <= nxt != READ;
            SRAM_WE_N  <= nxt != WRITE;
            SRAM_LB_N  <= nxt == READ ? 1'b0 : nxt == WRITE ? ~head.be[0] : 1'b1;
            SRAM_UB_N  <= nxt == READ ? 1'b0 : nxt == WRITE ? ~head.be[1] : 1'b1;
            dq_oe      <= nxt == WRITE;
            dq_out     <= head.d;
            drop       <= state == WRITE && disp_req;
            disp_valid <= state == READ || drop;
            disp_data  <= state == READ ? SRAM_DQ : drop ? 16'h0000 : disp_data;
            ovr_err    <= ovr_err || (state == WRITE && disp_req);
        end
    end

`ifdef SRAM_ARB_STATS_EN
    logic act_q;

    // Count completed writes, saturating; restart at each rising edge of disp_active.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_q    <= 1'b0;
            wr_count <= '0;
        end else begin
            act_q    <= disp_active;
            wr_count <= disp_active && !act_q ? 16'h0000 :
                        state == WRITE && wr_count != 16'hFFFF ? wr_count + 16'd1 : wr_count;
        end
    end
`endif
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed tests for sram_arbiter with a simple SRAM model (read data = address low 16 bits).
module tb_sram_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        disp_active = 1'b0, disp_req = 1'b0, wr_valid = 1'b0;
    logic [19:0] disp_addr = '0, wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [1:0]  wr_be = '0;
    logic        disp_valid, wr_ready, ovr_err;
    logic [15:0] disp_data;
    logic [4:0]  fifo_level;
    logic [19:0] SRAM_ADDR;
    wire  [15:0] SRAM_DQ;
    logic        SRAM_OE_N, SRAM_WE_N, SRAM_CE_N, SRAM_LB_N, SRAM_UB_N;
`ifdef SRAM_ARB_STATS_EN
    logic [15:0] wr_count;
`endif
    int tests = 0, fails = 0, cyc = 0, start = 0;
    int          wl_cyc[$];
    logic [19:0] wl_addr[$];
    logic [15:0] wl_data[$];
    logic [1:0]  wl_be[$];

    sram_arbiter #(.FIFO_DEPTH(16), .ADDR_W(20)) dut (
        .clk(clk), .rst(rst), .disp_active(disp_active), .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_valid(disp_valid), .disp_data(disp_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be), .fifo_level(fifo_level), .ovr_err(ovr_err),
`ifdef SRAM_ARB_STATS_EN
        .wr_count(wr_count),
`endif
        .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ), .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N),
        .SRAM_CE_N(SRAM_CE_N), .SRAM_LB_N(SRAM_LB_N), .SRAM_UB_N(SRAM_UB_N)
    );

    assign SRAM_DQ = (!SRAM_OE_N && !SRAM_CE_N) ? SRAM_ADDR[15:0] : 16'hzzzz;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (!SRAM_WE_N) begin
            wl_cyc.push_back(cyc);
            wl_addr.push_back(SRAM_ADDR);
            wl_data.push_back(SRAM_DQ);
            wl_be.push_back({~SRAM_UB_N, ~SRAM_LB_N});
        end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [19:0] a, input logic [15:0] d, input logic [1:0] be);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        wr_be    = be;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic clear_log();
        wl_cyc.delete();
        wl_addr.delete();
        wl_data.delete();
        wl_be.delete();
    endtask

    task automatic wait_we(input string tag);
        for (int i = 0; i < 10 && SRAM_WE_N; i++) tick();
        check(tag, SRAM_WE_N, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_we", SRAM_WE_N, 1'b1);
        check("rst_ce", SRAM_CE_N, 1'b1);
        check("rst_oe", SRAM_OE_N, 1'b1);
        check("rst_addr", SRAM_ADDR, 20'h0);
        check("rst_level", fifo_level, 5'd0);
        check("rst_ready", wr_ready, 1'b1);
        check("rst_valid", disp_valid, 1'b0);
        check("rst_ovr", ovr_err, 1'b0);
`ifdef SRAM_ARB_STATS_EN
        check("rst_wr_count", wr_count, 16'h0);
`endif
        rst = 1'b1;
        tick();

        disp_active = 1'b1;
        tick();
        tick();
        clear_log();
        for (int k = 0; k < 7; k++) begin
            check($sformatf("rd_valid_%0d", k), disp_valid, k >= 2 && k <= 5);
            if (k >= 2 && k <= 5) check($sformatf("rd_data_%0d", k), disp_data, 16'h0100 + 16'(k - 2));
            if (k >= 1 && k <= 4) begin
                check($sformatf("rd_oe_%0d", k), SRAM_OE_N, 1'b0);
                check($sformatf("rd_addr_%0d", k), SRAM_ADDR, 20'h00100 + 20'(k - 1));
            end
            disp_req  = k < 4;
            disp_addr = 20'h00100 + 20'(k);
            tick();
        end
        disp_req = 1'b0;
        check("rd_no_write", wl_cyc.size(), 0);

        push(20'h12345, 16'hBEEF, 2'b11);
        push(20'h12346, 16'h00AA, 2'b01);
        push(20'h12347, 16'h5555, 2'b00);
        check("drain_level3", fifo_level, 5'd3);
        clear_log();
        disp_active = 1'b0;
        repeat (8) tick();
        check("drain_count", wl_cyc.size(), 2);
        if (wl_cyc.size() == 2) begin
            check("drain_addr0", wl_addr[0], 20'h12345);
            check("drain_data0", wl_data[0], 16'hBEEF);
            check("drain_be0", wl_be[0], 2'b11);
            check("drain_addr1", wl_addr[1], 20'h12346);
            check("drain_data1_lo", wl_data[1][7:0], 8'hAA);
            check("drain_be1", wl_be[1], 2'b01);
            check("drain_gap", wl_cyc[1] - wl_cyc[0], 2);
        end
        check("drain_level0", fifo_level, 5'd0);
        check("drain_idle_ce", SRAM_CE_N, 1'b1);

        disp_active = 1'b1;
        tick();
        for (int i = 0; i < 17; i++) begin
            if (i == 15) check("bp_ready15", wr_ready, 1'b1);
            if (i == 16) check("bp_ready16", wr_ready, 1'b0);
            wr_valid = 1'b1;
            wr_addr  = 20'h00200 + 20'(i);
            wr_data  = 16'(i);
            wr_be    = 2'b11;
            tick();
        end
        wr_valid = 1'b0;
        check("bp_level16", fifo_level, 5'd16);
        check("bp_no_write", SRAM_WE_N, 1'b1);
        clear_log();
        start = cyc;
        disp_active = 1'b0;
        repeat (34) tick();
        check("bp_count", wl_cyc.size(), 16);
        if (wl_cyc.size() == 16) begin
            check("bp_first_cyc", wl_cyc[0] - start, 1);
            check("bp_last_cyc", wl_cyc[15] - start, 31);
            check("bp_last_addr", wl_addr[15], 20'h0020F);
        end
        check("bp_level0", fifo_level, 5'd0);
        check("bp_ready_again", wr_ready, 1'b1);

        disp_active = 1'b1;
        push(20'h00300, 16'h1234, 2'b11);
        disp_active = 1'b0;
        wait_we("col_wait_we");
        disp_req  = 1'b1;
        disp_addr = 20'h00055;
        tick();
        disp_req = 1'b0;
        check("col_ovr", ovr_err, 1'b1);
        check("col_valid_n1", disp_valid, 1'b0);
        tick();
        check("col_valid_n2", disp_valid, 1'b1);
        check("col_data_zero", disp_data, 16'h0000);
        tick();
        check("col_valid_n3", disp_valid, 1'b0);
        disp_active = 1'b1;
        disp_req    = 1'b1;
        disp_addr   = 20'h00456;
        tick();
        disp_req = 1'b0;
        tick();
        check("col_next_valid", disp_valid, 1'b1);
        check("col_next_data", disp_data, 16'h0456);
        check("col_ovr_sticky", ovr_err, 1'b1);

        push(20'h00400, 16'hAAAA, 2'b11);
        push(20'h00401, 16'hBBBB, 2'b11);
        disp_active = 1'b0;
        wait_we("rstw_wait_we");
        #2;
        rst = 1'b0;
        #1;
        check("rstw_we", SRAM_WE_N, 1'b1);
        check("rstw_ce", SRAM_CE_N, 1'b1);
        check("rstw_level", fifo_level, 5'd0);
        check("rstw_ready", wr_ready, 1'b1);
        check("rstw_ovr", ovr_err, 1'b0);
        tick();
        rst = 1'b1;
        tick();

`ifdef SRAM_ARB_STATS_EN
        disp_active = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) push(20'h00500 + 20'(i), 16'(i), 2'b11);
        disp_active = 1'b0;
        repeat (12) tick();
        check("stats_before", wr_count, 16'd5);
        disp_active = 1'b1;
        tick();
        check("stats_after", wr_count, 16'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
